// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), total derivation and
// region-compare helpers used by the sync generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;

  // Total length of one axis: active -> front porch -> sync -> back porch.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Position lies in the visible part of the axis.
  function automatic logic in_active(input int pos, input int active);
    return (pos < active);
  endfunction

  // Position lies inside the sync pulse, which follows active and front porch.
  function automatic logic in_sync(input int pos, input int active, input int fp, input int sync);
    return (pos >= (active + fp)) && (pos < (active + fp + sync));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo counter for one raster axis: counts 0..MODULUS-1 while enabled,
// reloads INIT on reset, and flags the enabled step that wraps to 0.
module vga_axis_counter #(
  parameter int CW      = 10,
  parameter int MODULUS = 800,
  parameter int INIT    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST     = CW'(MODULUS - 1);
  localparam logic [CW-1:0] INIT_VAL = CW'(INIT);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Carry is combinational so the next axis steps on the same edge as the wrap.
  assign wrap = en && (count == LAST);

  // Count register: wrap to zero at the end of the axis, otherwise step when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT_VAL;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: registered hsync/vsync, raw x/y, de and
// line/frame start strobes, advancing once per pix_ce.
// Optional look-ahead fetch position is built when VGA_SYNC_GEN_PREFETCH_EN
// is defined; otherwise fetch_x/fetch_y/fetch_de are constant 0.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = DEF_CW,
  parameter int PREFETCH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_de
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          h_wrap;
  logic          v_wrap;

  // Horizontal position steps on every pixel strobe.
  vga_axis_counter #(.CW(CW), .MODULUS(H_TOTAL), .INIT(0)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_ce),
    .count (h),
    .wrap  (h_wrap)
  );

  // Vertical position steps only when the line wraps.
  vga_axis_counter #(.CW(CW), .MODULUS(V_TOTAL), .INIT(0)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .count (v),
    .wrap  (v_wrap)
  );

  // Output stage: capture the current position and its decoded timing on each strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      x           <= h;
      y           <= v;
      de          <= in_active(int'(h), H_ACTIVE) && in_active(int'(v), V_ACTIVE);
      hsync       <= in_sync(int'(h), H_ACTIVE, H_FP, H_SYNC) ? HS_POL : ~HS_POL;
      vsync       <= in_sync(int'(v), V_ACTIVE, V_FP, V_SYNC) ? VS_POL : ~VS_POL;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end else begin
      x           <= x;
      y           <= y;
      de          <= de;
      hsync       <= hsync;
      vsync       <= vsync;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_SYNC_GEN_PREFETCH_EN
  // Look-ahead counters start PREFETCH pixels past (0,0) and then track h/v step for step.
  localparam int FETCH_H0 = PREFETCH % H_TOTAL;
  localparam int FETCH_V0 = (PREFETCH / H_TOTAL) % V_TOTAL;

  logic [CW-1:0] fh;
  logic [CW-1:0] fv;
  logic          fh_wrap;
  logic          fv_wrap;

  vga_axis_counter #(.CW(CW), .MODULUS(H_TOTAL), .INIT(FETCH_H0)) u_fh_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_ce),
    .count (fh),
    .wrap  (fh_wrap)
  );

  vga_axis_counter #(.CW(CW), .MODULUS(V_TOTAL), .INIT(FETCH_V0)) u_fv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (fh_wrap),
    .count (fv),
    .wrap  (fv_wrap)
  );

  // Look-ahead outputs are registered exactly like x/y/de so the lead stays PREFETCH strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_x  <= '0;
      fetch_y  <= '0;
      fetch_de <= 1'b0;
    end else if (pix_ce) begin
      fetch_x  <= fh;
      fetch_y  <= fv;
      fetch_de <= in_active(int'(fh), H_ACTIVE) && in_active(int'(fv), V_ACTIVE);
    end else begin
      fetch_x  <= fetch_x;
      fetch_y  <= fetch_y;
      fetch_de <= fetch_de;
    end
  end

  // Frame-wrap carries have no consumer; sink them explicitly.
  logic unused_carry;
  assign unused_carry = v_wrap ^ fv_wrap;
`else
  // No look-ahead path in this build: fetch port is constant zero.
  assign fetch_x  = '0;
  assign fetch_y  = '0;
  assign fetch_de = 1'b0;

  // Frame-wrap carry and look-ahead distance have no consumer in this build.
  logic unused_carry;
  assign unused_carry = v_wrap;
  localparam int unused_prefetch = PREFETCH;
`endif

endmodule
